pid_term_scheduler: RTL and testbench



---
 rtl/pid_pkg.sv | 35 +++
 rtl/pid_term_scheduler_if.sv | 30 +++
 rtl/pid_serial_mul.sv | 44 ++++
 rtl/pid_term_scheduler.sv | 157 +++++++++++++++
 tb/tb_pid_term_scheduler.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pid_pkg.sv
// Shared widths, FSM state type and the saturation helper for the PID scheduler.
package pid_pkg;

    localparam int ERR_W = 6;
    localparam int SUM_W = 8;
    localparam int ACC_W = 16;
    localparam int OUT_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL_P = 3'd1,
        MUL_I = 3'd2,
        MUL_D = 3'd3,
        DONE  = 3'd4
    } pid_state_t;

    // Clamp a signed accumulator-wide value to the two's-complement range of
    // 'width' bits. The result is still ACC_W wide; callers truncate it.
    function automatic logic signed [ACC_W-1:0] sat(input logic signed [ACC_W-1:0] value,
                                                    input int width);
        int v;
        int hi;
        int lo;
        v  = int'(value);
        hi = (1 << (width - 1)) - 1;
        lo = -hi - 1;
        if (v > hi) begin
            v = hi;
        end else if (v < lo) begin
            v = lo;
        end
        return ACC_W'(v);
    endfunction

endpackage

// File: rtl/pid_term_scheduler_if.sv
// Error-sample in / actuator-command out bundle of the PID scheduler.
// Handshake: a sample on e (with the gains) is taken on a rising clk edge where
// ena, sample_valid and ready are all high; sample_valid while ready is low is
// dropped and flagged on overrun. u_valid is a one-cycle pulse marking a new u;
// there is no back-pressure on the output side.
interface pid_term_scheduler_if;
    import pid_pkg::*;

    logic                    ena;
    logic                    sample_valid;
    logic signed [ERR_W-1:0] e;
    logic        [ERR_W-1:0] K_p;
    logic        [ERR_W-1:0] K_i;
    logic        [ERR_W-1:0] K_d;
    logic                    ready;
    logic                    u_valid;
    logic signed [OUT_W-1:0] u;
    logic                    overrun;

    modport master (
        output ena, sample_valid, e, K_p, K_i, K_d,
        input  ready, u_valid, u, overrun
    );

    modport slave (
        input  ena, sample_valid, e, K_p, K_i, K_d,
        output ready, u_valid, u, overrun
    );

endinterface

// File: rtl/pid_serial_mul.sv
// Shared repeated-addition multiplier: adds 'operand' into acc once per enabled
// cycle while its down-counter is non-zero. 'done' marks the last addition.
module pid_serial_mul
    import pid_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic                    start,
    input  logic                    preload,
    input  logic signed [ACC_W-1:0] acc_init,
    input  logic signed [ACC_W-1:0] operand,
    input  logic        [ERR_W-1:0] count,
    output logic signed [ACC_W-1:0] acc,
    output logic                    done
);

    logic [ERR_W-1:0] cnt;
    logic             busy;

    assign busy = (cnt != '0);
    assign done = (cnt == ERR_W'(1));

    // Accumulate while counting down; start reloads the count for the next term
    // on the same edge as the previous term's last addition.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (ena) begin
            if (preload) begin
                acc <= acc_init;
            end else if (busy) begin
                acc <= acc + operand;
            end
            if (start) begin
                cnt <= count;
            end else if (busy) begin
                cnt <= cnt - ERR_W'(1);
            end
        end
    end

endmodule

// File: rtl/pid_term_scheduler.sv
// Runs one PID update per accepted error sample, time-sharing a single serial
// multiplier across the P, I and D terms, then scales and saturates into u.
module pid_term_scheduler
    import pid_pkg::*;
#(
    parameter int SHIFT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pid_term_scheduler_if.slave  bus,
    output pid_state_t           fsm_state
);

    localparam int DIFF_W = ERR_W + 1;

    pid_state_t state;
    pid_state_t next_state;

    logic        [ERR_W-1:0]  k_p_q;
    logic        [ERR_W-1:0]  k_i_q;
    logic        [ERR_W-1:0]  k_d_q;
    logic signed [SUM_W-1:0]  e_sum;
    logic signed [ERR_W-1:0]  e_prev;
    logic signed [DIFF_W-1:0] diff;
    logic signed [OUT_W-1:0]  u;
    logic                     u_valid;
    logic                     overrun;

    logic                     accept;
    logic signed [ACC_W-1:0]  sum_wide;
    logic signed [DIFF_W-1:0] diff_next;
    logic                     mul_start;
    logic        [ERR_W-1:0]  mul_count;
    logic signed [ACC_W-1:0]  mul_operand;
    logic signed [ACC_W-1:0]  mul_acc;
    logic                     mul_done;

    assign accept    = bus.ena && bus.sample_valid && (state == IDLE);
    assign sum_wide  = ACC_W'(e_sum) + ACC_W'(bus.e);
    assign diff_next = DIFF_W'(bus.e) - DIFF_W'(e_prev);

    // State register; everything freezes while ena is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (bus.ena) begin
            state <= next_state;
        end
    end

    // Next state: zero-gain terms are skipped by jumping straight to the next
    // term with a non-zero gain (or DONE).
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (bus.K_p != '0)      next_state = MUL_P;
                    else if (bus.K_i != '0) next_state = MUL_I;
                    else if (bus.K_d != '0) next_state = MUL_D;
                    else                    next_state = DONE;
                end
            end
            MUL_P: begin
                if (mul_done) begin
                    if (k_i_q != '0)      next_state = MUL_I;
                    else if (k_d_q != '0) next_state = MUL_D;
                    else                  next_state = DONE;
                end
            end
            MUL_I: begin
                if (mul_done) begin
                    if (k_d_q != '0) next_state = MUL_D;
                    else             next_state = DONE;
                end
            end
            MUL_D: begin
                if (mul_done) next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Multiplier control: load the count of the term being entered and pick the
    // operand of the term currently running.
    always_comb begin
        mul_count   = '0;
        mul_operand = '0;
        case (next_state)
            MUL_P:   mul_count = (state == IDLE) ? bus.K_p : k_p_q;
            MUL_I:   mul_count = (state == IDLE) ? bus.K_i : k_i_q;
            MUL_D:   mul_count = (state == IDLE) ? bus.K_d : k_d_q;
            default: mul_count = '0;
        endcase
        mul_start = (next_state != state) && (mul_count != '0);
        case (state)
            MUL_P:   mul_operand = ACC_W'(e_prev);
            MUL_I:   mul_operand = ACC_W'(e_sum);
            MUL_D:   mul_operand = ACC_W'(diff);
            default: mul_operand = '0;
        endcase
    end

    pid_serial_mul u_mul (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (bus.ena),
        .start    (mul_start),
        .preload  (accept),
        .acc_init ('0),
        .operand  (mul_operand),
        .count    (mul_count),
        .acc      (mul_acc),
        .done     (mul_done)
    );

    // Sample state, overrun flag and the scaled, saturated output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k_p_q   <= '0;
            k_i_q   <= '0;
            k_d_q   <= '0;
            e_sum   <= '0;
            e_prev  <= '0;
            diff    <= '0;
            u       <= '0;
            u_valid <= 1'b0;
            overrun <= 1'b0;
        end else if (bus.ena) begin
            if (accept) begin
                k_p_q  <= bus.K_p;
                k_i_q  <= bus.K_i;
                k_d_q  <= bus.K_d;
                e_sum  <= SUM_W'(sat(sum_wide, SUM_W));
                diff   <= diff_next;
                e_prev <= bus.e;
            end
            if (bus.sample_valid && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            u_valid <= (state == DONE);
            if (state == DONE) begin
                u <= OUT_W'(sat(mul_acc >>> SHIFT, OUT_W));
            end
        end else begin
            u_valid <= 1'b0;
        end
    end

    assign bus.ready   = (state == IDLE);
    assign bus.u_valid = u_valid;
    assign bus.u       = u;
    assign bus.overrun = overrun;
    assign fsm_state   = state;

endmodule

// File: tb/tb_pid_term_scheduler.sv
// Two schedulers (SHIFT=0 and SHIFT=4) driven in lockstep from one stimulus
// stream; a scoreboard holds the model's expected u values and due cycles.
module tb_pid_term_scheduler;
    import pid_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                    ena = 1'b0;
    logic                    sample_valid = 1'b0;
    logic signed [ERR_W-1:0] e_drv = '0;
    logic        [ERR_W-1:0] kp = '0;
    logic        [ERR_W-1:0] ki = '0;
    logic        [ERR_W-1:0] kd = '0;

    pid_term_scheduler_if if0 ();
    pid_term_scheduler_if if4 ();

    assign if0.ena = ena;          assign if4.ena = ena;
    assign if0.sample_valid = sample_valid;
    assign if4.sample_valid = sample_valid;
    assign if0.e = e_drv;          assign if4.e = e_drv;
    assign if0.K_p = kp;           assign if4.K_p = kp;
    assign if0.K_i = ki;           assign if4.K_i = ki;
    assign if0.K_d = kd;           assign if4.K_d = kd;

    pid_state_t st0;
    pid_state_t st4;

    pid_term_scheduler #(.SHIFT(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave), .fsm_state(st0));
    pid_term_scheduler #(.SHIFT(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave), .fsm_state(st4));

    // ---------------- scoreboard ----------------
    logic [OUT_W-1:0] exp_q0[$];
    logic [OUT_W-1:0] exp_q4[$];
    int               due_q[$];
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int m_sum = 0;
    int m_prev = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic int floor_div16(input int v);
        if (v >= 0) return v / 16;
        return -((-v + 15) / 16);
    endfunction

    // enabled-cycle counter: latency is measured in edges where ena is high
    initial forever begin
        @(posedge clk);
        if (rst_n && ena) cyc = cyc + 1;
    end

    task automatic pop_and_check();
        logic [OUT_W-1:0] x0;
        logic [OUT_W-1:0] x4;
        int d;
        if (exp_q0.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_u_valid: got u=%0d, expected no output", $signed(if0.u));
            return;
        end
        x0 = exp_q0.pop_front();
        x4 = exp_q4.pop_front();
        d  = due_q.pop_front();
        check("u_shift0", int'($signed(if0.u)), int'($signed(x0)));
        check("u_shift4", int'($signed(if4.u)), int'($signed(x4)));
        check("latency", cyc, d);
        check("ready_with_u_valid", int'(if0.ready), 1);
    endtask

    // monitor
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (if0.u_valid !== if4.u_valid) begin
                n_vec++;
                n_err++;
                $display("FAIL u_valid_lockstep: got %b, expected %b", if4.u_valid, if0.u_valid);
            end
            if (if0.u_valid === 1'b1) pop_and_check();
        end
    end

    // ---------------- driver tasks ----------------
    task automatic model_reset();
        m_sum  = 0;
        m_prev = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Issue one sample once the DUT is idle; returns at the negedge after accept.
    task automatic send(input int ev, input int p, input int i, input int d, input bit expect_out);
        int guard;
        int diff_m;
        int acc_m;
        int v0;
        int v4;
        guard = 0;
        while (if0.ready !== 1'b1 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) begin
            n_vec++;
            n_err++;
            $display("FAIL ready_timeout: got ready=%b, expected 1", if0.ready);
            return;
        end
        e_drv = ev[ERR_W-1:0];
        kp = p[ERR_W-1:0];
        ki = i[ERR_W-1:0];
        kd = d[ERR_W-1:0];
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        // scramble gains: the update in flight must use the latched values
        kp = 6'($urandom_range(0, 63));
        ki = 6'($urandom_range(0, 63));
        kd = 6'($urandom_range(0, 63));
        m_sum  = clamp(m_sum + ev, -128, 127);
        diff_m = ev - m_prev;
        m_prev = ev;
        acc_m  = p * ev + i * m_sum + d * diff_m;
        v0 = clamp(acc_m, -128, 127);
        v4 = clamp(floor_div16(acc_m), -128, 127);
        if (expect_out) begin
            exp_q0.push_back(v0[OUT_W-1:0]);
            exp_q4.push_back(v4[OUT_W-1:0]);
            due_q.push_back(cyc + p + i + d + 1);
        end
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((exp_q0.size() != 0 || if0.ready !== 1'b1) && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 400) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q0.size());
            exp_q0.delete();
            exp_q4.delete();
            due_q.delete();
        end
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        ena = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        check("reset_ready", int'(if0.ready), 1);
        check("reset_u_valid", int'(if0.u_valid), 0);
        check("reset_u", int'($signed(if0.u)), 0);
        check("reset_overrun", int'(if0.overrun), 0);
        check("reset_state", int'(st0), int'(IDLE));

        // proportional
        send(5, 3, 0, 0, 1);
        wait_idle();
        check("ready_after_p", int'(if0.ready), 1);

        // integral
        do_reset();
        send(10, 0, 2, 0, 1);
        send(10, 0, 2, 0, 1);
        wait_idle();

        // derivative
        do_reset();
        send(4, 0, 0, 1, 1);
        send(-3, 0, 0, 1, 1);
        wait_idle();

        // integral saturation
        do_reset();
        for (int n = 0; n < 5; n++) send(31, 0, 63, 0, 1);
        wait_idle();

        // all gains zero
        send(-7, 0, 0, 0, 1);
        wait_idle();

        // freeze during MUL_I; a sample strobe while frozen is ignored
        do_reset();
        send(6, 0, 4, 0, 1);
        @(negedge clk);
        ena = 1'b0;
        check("freeze_state_start", int'(st0), int'(MUL_I));
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("freeze_state_end", int'(st0), int'(MUL_I));
        check("freeze_no_overrun", int'(if0.overrun), 0);
        ena = 1'b1;
        wait_idle();

        // overrun: second strobe two cycles after accept is dropped
        do_reset();
        send(1, 10, 0, 0, 1);
        @(negedge clk);
        e_drv = 6'sd7;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        check("overrun_set", int'(if0.overrun), 1);
        check("overrun_set_s4", int'(if4.overrun), 1);
        wait_idle();
        send(3, 0, 0, 1, 1);   // diff uses e_prev=1 from the accepted sample
        wait_idle();
        check("overrun_sticky", int'(if0.overrun), 1);

        // reset during MUL_D aborts the update
        do_reset();
        send(2, 1, 1, 10, 0);
        repeat (2) @(negedge clk);
        check("abort_in_mul_d", int'(st0), int'(MUL_D));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check("abort_u", int'($signed(if0.u)), 0);
        check("abort_ready", int'(if0.ready), 1);
        check("abort_overrun", int'(if0.overrun), 0);
        repeat (20) @(negedge clk);
        check("abort_no_u_valid", int'(if0.u_valid), 0);

        // randomized samples
        for (int n = 0; n < 30; n++) begin
            int ev;
            int p;
            int i;
            int d;
            ev = int'($urandom_range(0, 63)) - 32;
            p  = ($urandom_range(0, 5) == 0) ? 63 : int'($urandom_range(0, 7));
            i  = ($urandom_range(0, 5) == 0) ? 63 : int'($urandom_range(0, 7));
            d  = ($urandom_range(0, 5) == 0) ? 63 : int'($urandom_range(0, 7));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(ev, p, i, d, 1);
        end
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // watchdog
    initial begin
        #500000;
        n_err++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
